// File: rtl/divider_arbiter.sv
// divider_arbiter
//   Shares one multi-cycle 8-bit divider between four requesters. Each
//   requester owns a one-deep holding register; a round-robin FSM picks the
//   next pending requester, launches the divider, waits for the result
//   (bounded by a timeout), and returns it on a shared response bus with a
//   one-hot completion pulse.
//
// Ports
//   clk, rst                        clock, synchronous active-low reset
//   req_valid[3:0] / req_ready[3:0] per-requester handshake
//   req_dividend / req_divisor      requester i operands at bits [8i+7:8i]
//   rsp_valid[3:0]                  one-cycle completion pulse per requester
//   rsp_quotient/remainder/err      shared result, held until the next response
//   div_strt, div_dividend/divisor  divider launch and operands
//   div_quotient/remainder          divider results
//   div_infinite, div_idle          divider divide-by-zero and idle flags
//   busy                            high whenever the FSM is not arbitrating
//
// Parameter
//   TIMEOUT_CYCLES                  WAIT_DONE cycles before the op is aborted
//
// Build option
//   DIVIDER_ARBITER_ZERO_BYPASS_EN  when defined, a zero divisor is answered
//                                   directly from ARB (q=FF, r=dividend, err=1)
//                                   without starting the divider.

module divider_arbiter #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,
    output logic [3:0]  rsp_valid,
    output logic [7:0]  rsp_quotient,
    output logic [7:0]  rsp_remainder,
    output logic        rsp_err,
    output logic        div_strt,
    output logic [7:0]  div_dividend,
    output logic [7:0]  div_divisor,
    input  logic [7:0]  div_quotient,
    input  logic [7:0]  div_remainder,
    input  logic        div_infinite,
    input  logic        div_idle,
    output logic        busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_ARB,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_DONE,
        S_RESPOND
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pend_q, pend_d, pend_clr;
    logic [3:0][7:0]  hold_dd_q, hold_dv_q;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       rr_pick;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ws_q, ws_d;
    logic [7:0]       rquo_q, rquo_d;
    logic [7:0]       rrem_q, rrem_d;
    logic             rerr_q, rerr_d;

    // Round-robin: first pending index after last_q. Scanning the offsets
    // from far to near lets the nearest pending index win; offset 4 wraps
    // back to last_q itself so a lone requester can be served repeatedly.
    always_comb begin
        rr_pick = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (pend_q[2'(last_q + 2'(k))]) begin
                rr_pick = 2'(last_q + 2'(k));
            end
        end
    end

    // A requester's slot is frozen while pending; the clear from RESPOND only
    // ever targets a pending slot, so it can never collide with an accept.
    assign pend_d    = (pend_q & ~pend_clr) | (req_valid & ~pend_q);
    assign req_ready = ~pend_q;
    assign busy      = (state_q != S_ARB);

    assign rsp_quotient  = rquo_q;
    assign rsp_remainder = rrem_q;
    assign rsp_err       = rerr_q;

    // Operands are presented only while the divider owns the operation.
    always_comb begin
        div_dividend = 8'd0;
        div_divisor  = 8'd0;
        if (state_q == S_LAUNCH || state_q == S_WAIT_START || state_q == S_WAIT_DONE) begin
            div_dividend = hold_dd_q[grant_q];
            div_divisor  = hold_dv_q[grant_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        ws_d      = ws_q;
        rquo_d    = rquo_q;
        rrem_d    = rrem_q;
        rerr_d    = rerr_q;
        pend_clr  = 4'd0;
        div_strt  = 1'b0;
        rsp_valid = 4'd0;

        case (state_q)
            S_ARB: begin
                cnt_d = '0;
                ws_d  = 1'b0;
                if ((|pend_q) && div_idle) begin
                    grant_d = rr_pick;
                    state_d = S_LAUNCH;
`ifdef DIVIDER_ARBITER_ZERO_BYPASS_EN
                    if (hold_dv_q[rr_pick] == 8'd0) begin
                        rquo_d  = 8'hFF;
                        rrem_d  = hold_dd_q[rr_pick];
                        rerr_d  = 1'b1;
                        state_d = S_RESPOND;
                    end
`endif
                end
            end

            S_LAUNCH: begin
                div_strt = 1'b1;
                err_d    = div_infinite;
                cnt_d    = '0;
                ws_d     = 1'b0;
                state_d  = S_WAIT_START;
            end

            // The divider must leave idle within two cycles of the start
            // pulse; otherwise it never accepted the operation.
            S_WAIT_START: begin
                if (!div_idle) begin
                    state_d = S_WAIT_DONE;
                end else if (ws_q) begin
                    rquo_d  = 8'd0;
                    rrem_d  = 8'd0;
                    rerr_d  = 1'b1;
                    state_d = S_RESPOND;
                end else begin
                    ws_d = 1'b1;
                end
            end

            // cnt_q counts completed WAIT_DONE cycles, so cnt_q == T-1 means
            // this is the T-th cycle and the counter reaches T at its end.
            S_WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (div_idle) begin
                    rquo_d  = div_quotient;
                    rrem_d  = div_remainder;
                    rerr_d  = err_q;
                    state_d = S_RESPOND;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rquo_d  = 8'd0;
                    rrem_d  = 8'd0;
                    rerr_d  = 1'b1;
                    state_d = S_RESPOND;
                end
            end

            S_RESPOND: begin
                rsp_valid[grant_q] = 1'b1;
                pend_clr[grant_q]  = 1'b1;
                last_d             = grant_q;
                state_d            = S_ARB;
            end

            default: state_d = S_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_ARB;
            pend_q    <= 4'd0;
            hold_dd_q <= '0;
            hold_dv_q <= '0;
            grant_q   <= 2'd0;
            last_q    <= 2'd3;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            ws_q      <= 1'b0;
            rquo_q    <= 8'd0;
            rrem_q    <= 8'd0;
            rerr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ws_q    <= ws_d;
            rquo_q  <= rquo_d;
            rrem_q  <= rrem_d;
            rerr_q  <= rerr_d;
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && !pend_q[i]) begin
                    hold_dd_q[i] <= req_dividend[8*i +: 8];
                    hold_dv_q[i] <= req_divisor[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios followed by randomized
// batches, with a behavioural divider model and a round-robin reference.
module tb_divider_arbiter;

    localparam int T = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_dividend, req_divisor;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_quotient, rsp_remainder;
    logic        rsp_err;
    logic        div_strt;
    logic [7:0]  div_dividend, div_divisor;
    logic [7:0]  div_quotient, div_remainder;
    logic        div_infinite, div_idle;
    logic        busy;

    always #5 clk = ~clk;

    divider_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
        .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
        .div_strt(div_strt), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_infinite(div_infinite), .div_idle(div_idle),
        .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    // Divider model. mode 0: finishes after lat+1 busy cycles; 1: never
    // finishes; 2: ignores the start pulse. lat_cfg < 0 picks a random latency.
    int         mode = 0;
    int         lat_cfg = 2;
    logic       m_clr = 1'b0;
    logic       m_idle = 1'b1;
    int         m_cnt = 0;
    logic [7:0] m_q = 8'd0;
    logic [7:0] m_r = 8'd0;

    assign div_idle      = m_idle;
    assign div_quotient  = m_q;
    assign div_remainder = m_r;
    assign div_infinite  = (div_divisor == 8'd0);

    always @(posedge clk) begin
        if (m_clr) begin
            m_idle <= 1'b1;
            m_cnt  <= 0;
        end else if (div_strt && mode != 2) begin
            m_idle <= 1'b0;
            m_cnt  <= (lat_cfg < 0) ? int'($urandom_range(0, 6)) : lat_cfg;
            if (div_divisor == 8'd0) begin
                m_q <= 8'hFF;
                m_r <= div_dividend;
            end else begin
                m_q <= div_dividend / div_divisor;
                m_r <= div_dividend % div_divisor;
            end
        end else if (!m_idle && mode == 0) begin
            if (m_cnt == 0) m_idle <= 1'b1;
            else            m_cnt  <= m_cnt - 1;
        end
    end

    int cyc = 0;
    int launch_cyc = 0;
    int strt_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_strt) begin
            launch_cyc <= cyc;
            strt_cnt   <= strt_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        m_clr = 1'b1;
        tick();
        tick();
        rst   = 1'b1;
        m_clr = 1'b0;
    endtask

    task automatic issue(input logic [3:0] mask, input logic [31:0] dd, input logic [31:0] dv);
        check("ready_before_issue", req_ready & mask, mask);
        req_valid    = mask;
        req_dividend = dd;
        req_divisor  = dv;
        tick();
        req_valid = 4'd0;
    endtask

    task automatic issue1(input int idx, input logic [7:0] a, input logic [7:0] b);
        issue(4'(1 << idx), 32'(a) << (8 * idx), 32'(b) << (8 * idx));
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid != 4'd0) break;
            tick();
        end
        check({tag, "_seen"}, 32'(rsp_valid != 4'd0), 32'd1);
    endtask

    task automatic wait_strt(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (div_strt) break;
            tick();
        end
        check({tag, "_strt_seen"}, 32'(div_strt), 32'd1);
    endtask

    // Reference for one result, from plain arithmetic.
    task automatic expect_rsp(input string tag, input int idx, input logic [7:0] a, input logic [7:0] b);
        check({tag, "_valid"}, rsp_valid, 32'(1 << idx));
        if (b == 8'd0) begin
            check({tag, "_err"}, rsp_err, 1);
            check({tag, "_q"}, rsp_quotient, 8'hFF);
            check({tag, "_r"}, rsp_remainder, a);
        end else begin
            check({tag, "_err"}, rsp_err, 0);
            check({tag, "_q"}, rsp_quotient, 32'(a / b));
            check({tag, "_r"}, rsp_remainder, 32'(a % b));
        end
    endtask

    initial begin
        int s0;
        logic [3:0] seen;
        logic [7:0] dd[4];
        logic [7:0] dv[4];
        logic [3:0] rem;
        int last_exp;
        int nxt;

        rst = 1'b0;
        req_valid = 4'd0;
        req_dividend = 32'd0;
        req_divisor = 32'd0;
        do_reset();

        // Reset state
        check("rst_ready", req_ready, 4'hF);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_div_strt", div_strt, 0);
        check("rst_q", rsp_quotient, 0);
        check("rst_r", rsp_remainder, 0);
        check("rst_err", rsp_err, 0);
        check("rst_div_dd", div_dividend, 0);

        // Single operation 100/7 with fixed divider latency
        mode = 0; lat_cfg = 2;
        s0 = strt_cnt;
        issue1(0, 8'd100, 8'd7);
        check("one_ready_low", req_ready, 4'hE);
        wait_strt("one");
        check("one_div_dd", div_dividend, 100);
        check("one_div_dv", div_divisor, 7);
        check("one_busy", busy, 1);
        wait_rsp("one");
        expect_rsp("one", 0, 8'd100, 8'd7);
        check("one_latency", cyc - launch_cyc, lat_cfg + 3);
        tick();
        check("one_pulse_len", rsp_valid, 0);
        check("one_reissue_ready", req_ready, 4'hF);
        check("one_hold_q", rsp_quotient, 14);
        check("one_strt_count", strt_cnt - s0, 1);
        check("one_div_dd_idle", div_dividend, 0);

        // All four in the same cycle, fresh reset so requester 0 goes first
        do_reset();
        dd = '{8'd200, 8'd9, 8'd255, 8'd1};
        dv = '{8'd3, 8'd9, 8'd16, 8'd2};
        issue(4'hF, {dd[3], dd[2], dd[1], dd[0]}, {dv[3], dv[2], dv[1], dv[0]});
        for (int k = 0; k < 4; k++) begin
            wait_rsp($sformatf("all4_%0d", k));
            expect_rsp($sformatf("all4_%0d", k), k, dd[k], dv[k]);
            tick();
        end

        // Divide by zero
        s0 = strt_cnt;
        issue1(2, 8'd50, 8'd0);
        wait_rsp("zero");
        check("zero_valid", rsp_valid, 4'b0100);
        check("zero_err", rsp_err, 1);
`ifdef DIVIDER_ARBITER_ZERO_BYPASS_EN
        check("zero_q", rsp_quotient, 255);
        check("zero_r", rsp_remainder, 50);
        check("zero_strt_count", strt_cnt - s0, 0);
`else
        check("zero_strt_count", strt_cnt - s0, 1);
`endif
        tick();

        // Divider never finishes: timeout
        mode = 1;
        issue1(1, 8'd10, 8'd3);
        wait_rsp("tmo");
        check("tmo_valid", rsp_valid, 4'b0010);
        check("tmo_err", rsp_err, 1);
        check("tmo_q", rsp_quotient, 0);
        check("tmo_r", rsp_remainder, 0);
        check("tmo_latency", cyc - launch_cyc, T + 2);
        tick();
        mode = 0; m_clr = 1'b1; tick(); m_clr = 1'b0;

        // Divider never leaves idle: start failure after two WAIT_START cycles
        mode = 2;
        issue1(0, 8'd77, 8'd7);
        wait_rsp("nostart");
        check("nostart_valid", rsp_valid, 4'b0001);
        check("nostart_err", rsp_err, 1);
        check("nostart_latency", cyc - launch_cyc, 3);
        tick();
        mode = 0;

        // Reset during WAIT_DONE discards everything
        lat_cfg = 20;
        issue(4'b0101, {8'd0, 8'd9, 8'd0, 8'd40}, {8'd0, 8'd2, 8'd0, 8'd5});
        wait_strt("mid");
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy", busy, 1);
        rst = 1'b0; m_clr = 1'b1;
        tick();
        rst = 1'b1; m_clr = 1'b0;
        check("mid_ready_after_rst", req_ready, 4'hF);
        seen = 4'd0;
        for (int i = 0; i < 60; i++) begin
            seen = seen | rsp_valid;
            tick();
        end
        check("mid_no_rsp", seen, 0);
        check("mid_ready_idle", req_ready, 4'hF);
        check("mid_busy_idle", busy, 0);
        lat_cfg = 1;
        issue1(3, 8'd40, 8'd5);
        wait_rsp("after_rst");
        expect_rsp("after_rst", 3, 8'd40, 8'd5);
        tick();

        // Reissue right after response while another requester is pending
        do_reset();
        lat_cfg = 4;
        issue1(1, 8'd20, 8'd6);
        tick(); tick();
        issue1(3, 8'd30, 8'd4);
        wait_rsp("reiss_a");
        expect_rsp("reiss_a", 1, 8'd20, 8'd6);
        tick();
        check("reiss_ready", req_ready, 4'b0111);
        issue1(1, 8'd21, 8'd5);
        wait_rsp("reiss_b");
        expect_rsp("reiss_b", 3, 8'd30, 8'd4);
        tick();
        wait_rsp("reiss_c");
        expect_rsp("reiss_c", 1, 8'd21, 8'd5);
        tick();

        // Random batches against a round-robin reference
        do_reset();
        lat_cfg  = -1;
        last_exp = 3;
        for (int it = 0; it < 20; it++) begin
            rem = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) begin
                dd[k] = 8'($urandom_range(0, 255));
                dv[k] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            issue(rem, {dd[3], dd[2], dd[1], dd[0]}, {dv[3], dv[2], dv[1], dv[0]});
            while (rem != 4'd0) begin
                nxt = last_exp;
                for (int k = 1; k <= 4; k++) begin
                    if (rem[(last_exp + k) % 4]) begin
                        nxt = (last_exp + k) % 4;
                        break;
                    end
                end
                wait_rsp($sformatf("rnd%0d", it));
                expect_rsp($sformatf("rnd%0d_%0d", it, nxt), nxt, dd[nxt], dv[nxt]);
                rem[nxt] = 1'b0;
                last_exp = nxt;
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
